// File: rtl/ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the execute stage: bus widths, ALU operator codes,
// result category codes, enable/zero constants, divider FSM state encodings
// and a small conditional-negate helper used by the divider.
// No ports (package).
// -----------------------------------------------------------------------------
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 8;
  localparam int CAT_W      = 3;

  localparam logic              ENABLE    = 1'b1;
  localparam logic              DISABLE   = 1'b0;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0000_0000;

  // ALU operator codes (ID/EX operator field)
  localparam logic [OP_W-1:0] OP_NOP  = 8'b0000_0000;
  localparam logic [OP_W-1:0] OP_AND  = 8'b0010_0100;
  localparam logic [OP_W-1:0] OP_OR   = 8'b0010_0101;
  localparam logic [OP_W-1:0] OP_XOR  = 8'b0010_0110;
  localparam logic [OP_W-1:0] OP_NOR  = 8'b0010_0111;
  localparam logic [OP_W-1:0] OP_SLL  = 8'b0111_1100;
  localparam logic [OP_W-1:0] OP_SRL  = 8'b0000_0010;
  localparam logic [OP_W-1:0] OP_SRA  = 8'b0000_0011;
  localparam logic [OP_W-1:0] OP_ADD  = 8'b0010_0000;
  localparam logic [OP_W-1:0] OP_ADDU = 8'b0010_0001;
  localparam logic [OP_W-1:0] OP_SUB  = 8'b0010_0010;
  localparam logic [OP_W-1:0] OP_SUBU = 8'b0010_0011;
  localparam logic [OP_W-1:0] OP_SLT  = 8'b0010_1010;
  localparam logic [OP_W-1:0] OP_SLTU = 8'b0010_1011;
  localparam logic [OP_W-1:0] OP_MFHI = 8'b0001_0000;
  localparam logic [OP_W-1:0] OP_MTHI = 8'b0001_0001;
  localparam logic [OP_W-1:0] OP_MFLO = 8'b0001_0010;
  localparam logic [OP_W-1:0] OP_MTLO = 8'b0001_0011;
  localparam logic [OP_W-1:0] OP_DIV  = 8'b0001_1010;
  localparam logic [OP_W-1:0] OP_DIVU = 8'b0001_1011;

  // Result category codes
  localparam logic [CAT_W-1:0] CAT_NOP   = 3'b000;
  localparam logic [CAT_W-1:0] CAT_LOGIC = 3'b001;
  localparam logic [CAT_W-1:0] CAT_SHIFT = 3'b010;
  localparam logic [CAT_W-1:0] CAT_MOVE  = 3'b011;
  localparam logic [CAT_W-1:0] CAT_ARITH = 3'b100;
  localparam logic [CAT_W-1:0] CAT_DIV   = 3'b101;

  // Divider FSM states
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam int DIV_STEPS = 32;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] negate_if(input logic neg,
                                                   input logic [DATA_W-1:0] value);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative restoring divider, one quotient bit per cycle, 32 steps.
// FSM: IDLE -> BUSY (32 cycles) -> DONE -> IDLE; divide-by-zero goes
// straight IDLE -> DONE with quotient all-ones and remainder = dividend.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             DIV/DIVU request present in EX
//   signed_op         1 = DIV (signed), 0 = DIVU
//   annul             abandons any operation, back to IDLE next cycle
//   dividend, divisor raw operands from EX
//   busy              stall request (start cycle + 32 BUSY cycles)
//   done              result valid this cycle, commit at closing edge
//   quotient, remainder sign-corrected results (meaningful while done)
// -----------------------------------------------------------------------------
module div_unit
  import ex_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_op,
  input  logic              annul,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [1:0]        state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              divisor_zero;

  assign divisor_zero = (divisor == ZERO_WORD);

  // quot_q starts out holding the dividend magnitude and is shifted left each
  // step; the bit leaving its top enters the partial remainder while the new
  // quotient bit fills in from the bottom.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    shifted    = {rem_q, quot_q[DATA_W-1]};
    trial      = shifted - {1'b0, divisor_q};

    if (annul) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              quot_d     = 32'hFFFF_FFFF;
              rem_d      = dividend;
              neg_quot_d = 1'b0;
              neg_rem_d  = 1'b0;
              state_d    = DIV_DONE;
            end else begin
              quot_d     = negate_if(signed_op & dividend[DATA_W-1], dividend);
              divisor_d  = negate_if(signed_op & divisor[DATA_W-1], divisor);
              rem_d      = ZERO_WORD;
              count_d    = 6'd0;
              neg_quot_d = signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
              neg_rem_d  = signed_op & dividend[DATA_W-1];
              state_d    = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          // trial[32] set means the shifted remainder is below the divisor,
          // so the subtraction is discarded (restoring step).
          if (!trial[DATA_W]) begin
            rem_d  = trial[DATA_W-1:0];
            quot_d = {quot_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d  = shifted[DATA_W-1:0];
            quot_d = {quot_q[DATA_W-2:0], 1'b0};
          end
          count_d = count_q + 6'd1;
          if (count_q == 6'(DIV_STEPS - 1)) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      count_q    <= 6'd0;
      quot_q     <= ZERO_WORD;
      rem_q      <= ZERO_WORD;
      divisor_q  <= ZERO_WORD;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  // The start cycle already stalls so the pipeline holds the DIV in EX.
  assign busy = !annul && (((state_q == DIV_IDLE) && start && !divisor_zero) ||
                           (state_q == DIV_BUSY));
  assign done = !annul && (state_q == DIV_DONE);

  assign quotient  = negate_if(neg_quot_q, quot_q);
  assign remainder = negate_if(neg_rem_q, rem_q);

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage: combinational ALU (logic, shift, arithmetic, HI/LO moves),
// HI/LO registers and an optional iterative divider.
// Build option: define DIVIDER_EN to include the div_unit divider; without it
// the DIV category behaves as a NOP and stall_request is tied low.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   ex_operator, ex_category      operator / result category from ID/EX
//   ex_operand1, ex_operand2      source operands
//   ex_write_addr, ex_write_enable destination GPR and write request
//   annul                         cancels the instruction in EX
//   mem_write_addr/enable/data    GPR result towards EX/MEM
//   stall_request                 holds IF/ID/EX while a division runs
//   hi_out, lo_out                current HI/LO contents
// -----------------------------------------------------------------------------
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [OP_W-1:0]       ex_operator,
  input  logic [CAT_W-1:0]      ex_category,
  input  logic [DATA_W-1:0]     ex_operand1,
  input  logic [DATA_W-1:0]     ex_operand2,
  input  logic [REG_ADDR_W-1:0] ex_write_addr,
  input  logic                  ex_write_enable,
  input  logic                  annul,
  output logic [REG_ADDR_W-1:0] mem_write_addr,
  output logic                  mem_write_enable,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic                  stall_request,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] sum, diff, result;
  logic [4:0]        shamt;
  logic              add_ovf, sub_ovf, ovf_block;
  logic              slt_bit, sltu_bit;
  logic              div_done, div_as_nop;
  logic [DATA_W-1:0] div_quot, div_rem;

  always_comb begin
    shamt    = ex_operand1[4:0];
    sum      = ex_operand1 + ex_operand2;
    diff     = ex_operand1 - ex_operand2;
    // Signed overflow: result sign disagrees with the (effective) operand signs.
    add_ovf  = (ex_operand1[DATA_W-1] == ex_operand2[DATA_W-1]) &&
               (sum[DATA_W-1] != ex_operand1[DATA_W-1]);
    sub_ovf  = (ex_operand1[DATA_W-1] != ex_operand2[DATA_W-1]) &&
               (diff[DATA_W-1] != ex_operand1[DATA_W-1]);
    slt_bit  = $signed(ex_operand1) < $signed(ex_operand2);
    sltu_bit = ex_operand1 < ex_operand2;
    result   = ZERO_WORD;
    case (ex_category)
      CAT_LOGIC: begin
        case (ex_operator)
          OP_AND:  result = ex_operand1 & ex_operand2;
          OP_OR:   result = ex_operand1 | ex_operand2;
          OP_XOR:  result = ex_operand1 ^ ex_operand2;
          OP_NOR:  result = ~(ex_operand1 | ex_operand2);
          default: result = ZERO_WORD;
        endcase
      end
      CAT_SHIFT: begin
        case (ex_operator)
          OP_SLL:  result = ex_operand2 << shamt;
          OP_SRL:  result = ex_operand2 >> shamt;
          OP_SRA:  result = DATA_W'($signed(ex_operand2) >>> shamt);
          default: result = ZERO_WORD;
        endcase
      end
      CAT_ARITH: begin
        case (ex_operator)
          OP_ADD, OP_ADDU: result = sum;
          OP_SUB, OP_SUBU: result = diff;
          OP_SLT:          result = {{(DATA_W-1){1'b0}}, slt_bit};
          OP_SLTU:         result = {{(DATA_W-1){1'b0}}, sltu_bit};
          default:         result = ZERO_WORD;
        endcase
      end
      CAT_MOVE: begin
        case (ex_operator)
          OP_MFHI: result = hi_q;
          OP_MFLO: result = lo_q;
          default: result = ZERO_WORD;
        endcase
      end
      default: result = ZERO_WORD;
    endcase
    ovf_block = (ex_category == CAT_ARITH) &&
                (((ex_operator == OP_ADD) && add_ovf) ||
                 ((ex_operator == OP_SUB) && sub_ovf));
  end

`ifdef DIVIDER_EN
  logic div_start, div_busy;

  assign div_start = (ex_category == CAT_DIV) &&
                     ((ex_operator == OP_DIV) || (ex_operator == OP_DIVU));

  div_unit u_div_unit (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .signed_op (ex_operator == OP_DIV),
    .annul     (annul),
    .dividend  (ex_operand1),
    .divisor   (ex_operand2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  assign stall_request = div_busy && !reset;
  assign div_as_nop    = DISABLE;
`else
  assign stall_request = DISABLE;
  assign div_done      = DISABLE;
  assign div_quot      = ZERO_WORD;
  assign div_rem       = ZERO_WORD;
  assign div_as_nop    = (ex_category == CAT_DIV);
`endif

  // A divider commit wins over an MTHI/MTLO in the same cycle; annul blocks
  // the move-to writes but never a commit (the divider gates its own done).
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = div_rem;
      lo_d = div_quot;
    end else if (!annul) begin
      if (ex_operator == OP_MTHI) hi_d = ex_operand1;
      if (ex_operator == OP_MTLO) lo_d = ex_operand1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  assign mem_write_addr   = reset ? '0 : ex_write_addr;
  assign mem_write_data   = reset ? ZERO_WORD : result;
  assign mem_write_enable = ex_write_enable && !reset && !annul && !stall_request &&
                            !ovf_block && !div_as_nop && (ex_category != CAT_NOP);

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Directed-vector bench for ex_stage with a behavioural reference model
// (plain arithmetic, cycle counters for the divider) checked every cycle,
// plus hand-computed literal expectations. Adapts its expectations to the
// DIVIDER_EN build option.
// -----------------------------------------------------------------------------
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  ex_operator;
  logic [2:0]  ex_category;
  logic [31:0] ex_operand1;
  logic [31:0] ex_operand2;
  logic [4:0]  ex_write_addr;
  logic        ex_write_enable;
  logic        annul;
  logic [4:0]  mem_write_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        stall_request;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int compare_count = 0;
  int miss_count    = 0;
  int stall_cycles;
  bit check_en      = 1'b0;

  // Reference model state
  logic [31:0] m_hi     = 32'h0;
  logic [31:0] m_lo     = 32'h0;
  int          m_busy   = 0;
  bit          m_done   = 1'b0;
  logic [31:0] m_pend_q = 32'h0;
  logic [31:0] m_pend_r = 32'h0;

  ex_stage dut (
    .clock            (clock),
    .reset            (reset),
    .ex_operator      (ex_operator),
    .ex_category      (ex_category),
    .ex_operand1      (ex_operand1),
    .ex_operand2      (ex_operand2),
    .ex_write_addr    (ex_write_addr),
    .ex_write_enable  (ex_write_enable),
    .annul            (annul),
    .mem_write_addr   (mem_write_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .stall_request    (stall_request),
    .hi_out           (hi_out),
    .lo_out           (lo_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] model_data(input logic [7:0] op, input logic [2:0] cat,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
    int     sh;
    longint sa, sb, ua, ub;
    sh = int'(a[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (cat == CAT_LOGIC) begin
      if (op == OP_AND) return a & b;
      if (op == OP_OR)  return a | b;
      if (op == OP_XOR) return a ^ b;
      if (op == OP_NOR) return ~(a | b);
    end else if (cat == CAT_SHIFT) begin
      if (op == OP_SLL) return b << sh;
      if (op == OP_SRL) return b >> sh;
      if (op == OP_SRA) return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
    end else if (cat == CAT_ARITH) begin
      if (op == OP_ADD || op == OP_ADDU) return 32'(sa + sb);
      if (op == OP_SUB || op == OP_SUBU) return 32'(sa - sb);
      if (op == OP_SLT)  return (sa < sb) ? 32'd1 : 32'd0;
      if (op == OP_SLTU) return (ua < ub) ? 32'd1 : 32'd0;
    end else if (cat == CAT_MOVE) begin
      if (op == OP_MFHI) return hi;
      if (op == OP_MFLO) return lo;
    end
    return 32'h0;
  endfunction

  function automatic bit model_ovf(input logic [7:0] op, input logic [2:0] cat,
                                   input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (cat != CAT_ARITH) return 1'b0;
    if (op == OP_ADD)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == OP_SUB) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] model_div(input bit is_signed, input logic [31:0] a,
                                            input logic [31:0] b);
    int q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (is_signed) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  function automatic bit model_is_div();
    return DIV_EN && (ex_category == CAT_DIV) &&
           ((ex_operator == OP_DIV) || (ex_operator == OP_DIVU));
  endfunction

  function automatic bit model_stall();
    if (reset || annul) return 1'b0;
    if (m_busy > 0) return 1'b1;
    return !m_done && model_is_div() && (ex_operand2 != 32'h0);
  endfunction

  function automatic bit model_enable();
    return ex_write_enable && !reset && !annul && (ex_category != CAT_NOP) &&
           !model_stall() && !model_ovf(ex_operator, ex_category, ex_operand1, ex_operand2) &&
           !(!DIV_EN && (ex_category == CAT_DIV));
  endfunction

  // Model state advances on the same edge as the DUT.
  always @(posedge clock) begin
    if (reset) begin
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (annul) begin
      m_busy <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      m_hi   <= m_pend_r;
      m_lo   <= m_pend_q;
      m_done <= 1'b0;
    end else begin
      if (ex_operator == OP_MTHI) m_hi <= ex_operand1;
      if (ex_operator == OP_MTLO) m_lo <= ex_operand1;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_done <= 1'b1;
      end else if (model_is_div()) begin
        {m_pend_r, m_pend_q} <= model_div(ex_operator == OP_DIV, ex_operand1, ex_operand2);
        if (ex_operand2 == 32'h0) m_done <= 1'b1;
        else                      m_busy <= 32;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_stall", 32'(stall_request), 32'(model_stall()));
      checkOutput("model_enable", 32'(mem_write_enable), 32'(model_enable()));
      checkOutput("model_data", mem_write_data,
                  reset ? 32'h0 : model_data(ex_operator, ex_category, ex_operand1,
                                             ex_operand2, m_hi, m_lo));
      checkOutput("model_addr", 32'(mem_write_addr), reset ? 32'h0 : 32'(ex_write_addr));
      checkOutput("model_hi", hi_out, m_hi);
      checkOutput("model_lo", lo_out, m_lo);
    end
  end

  // Drives one EX-stage instruction for one cycle and returns mid-cycle.
  task automatic applyStimulus(input logic rst, input logic [7:0] op, input logic [2:0] cat,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] waddr, input logic we, input logic ann);
    @(posedge clock);
    #1;
    reset           = rst;
    ex_operator     = op;
    ex_category     = cat;
    ex_operand1     = a;
    ex_operand2     = b;
    ex_write_addr   = waddr;
    ex_write_enable = we;
    annul           = ann;
    @(negedge clock);
  endtask

  task automatic nop();
    applyStimulus(1'b0, OP_NOP, CAT_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ex_operator = OP_NOP; ex_category = CAT_NOP;
    ex_operand1 = 32'h0; ex_operand2 = 32'h0; ex_write_addr = 5'd0;
    ex_write_enable = 1'b0; annul = 1'b0;
    check_en = 1'b1;

    // Reset: outputs forced to zero even with a live instruction present
    applyStimulus(1'b1, OP_ADDU, CAT_ARITH, 32'h1, 32'h2, 5'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_ADDU, CAT_ARITH, 32'h1, 32'h2, 5'd7, 1'b1, 1'b0);
    checkOutput("reset_data", mem_write_data, 32'h0);
    checkOutput("reset_addr", 32'(mem_write_addr), 32'h0);
    checkOutput("reset_enable", 32'(mem_write_enable), 32'h0);
    checkOutput("reset_hi", hi_out, 32'h0);
    checkOutput("reset_lo", lo_out, 32'h0);
    checkOutput("reset_stall", 32'(stall_request), 32'h0);

    // Logic and shifts
    applyStimulus(1'b0, OP_AND, CAT_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 1'b1, 1'b0);
    checkOutput("and_literal", mem_write_data, 32'h00F0_1234);
    applyStimulus(1'b0, OP_OR,  CAT_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, OP_XOR, CAT_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, OP_NOR, CAT_LOGIC, 32'h0000_00FF, 32'h0F00_0000, 5'd4, 1'b1, 1'b0);
    checkOutput("nor_literal", mem_write_data, 32'hF0FF_FF00);
    applyStimulus(1'b0, OP_SLL, CAT_SHIFT, 32'h0000_0008, 32'h0000_0001, 5'd5, 1'b1, 1'b0);
    checkOutput("sll_literal", mem_write_data, 32'h0000_0100);
    applyStimulus(1'b0, OP_SRL, CAT_SHIFT, 32'h0000_0004, 32'h8000_0000, 5'd6, 1'b1, 1'b0);
    applyStimulus(1'b0, OP_SRA, CAT_SHIFT, 32'h0000_0024, 32'h8000_0000, 5'd6, 1'b1, 1'b0);
    checkOutput("sra_literal", mem_write_data, 32'hF800_0000);

    // Arithmetic, overflow suppression
    applyStimulus(1'b0, OP_ADD, CAT_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd8, 1'b1, 1'b0);
    checkOutput("add_ovf_enable", 32'(mem_write_enable), 32'h0);
    applyStimulus(1'b0, OP_ADDU, CAT_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd8, 1'b1, 1'b0);
    checkOutput("addu_data", mem_write_data, 32'h8000_0000);
    checkOutput("addu_enable", 32'(mem_write_enable), 32'h1);
    applyStimulus(1'b0, OP_ADD, CAT_ARITH, 32'h0000_0005, 32'hFFFF_FFFD, 5'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, OP_SUB, CAT_ARITH, 32'h8000_0000, 32'h0000_0001, 5'd9, 1'b1, 1'b0);
    checkOutput("sub_ovf_enable", 32'(mem_write_enable), 32'h0);
    applyStimulus(1'b0, OP_SUBU, CAT_ARITH, 32'h0000_0005, 32'h0000_0007, 5'd9, 1'b1, 1'b0);
    checkOutput("subu_literal", mem_write_data, 32'hFFFF_FFFE);
    applyStimulus(1'b0, OP_SLT, CAT_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 1'b1, 1'b0);
    checkOutput("slt_literal", mem_write_data, 32'h1);
    applyStimulus(1'b0, OP_SLTU, CAT_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 1'b1, 1'b0);
    checkOutput("sltu_literal", mem_write_data, 32'h0);
    applyStimulus(1'b0, OP_ADDU, CAT_NOP, 32'h1, 32'h1, 5'd11, 1'b1, 1'b0);
    checkOutput("nop_enable", 32'(mem_write_enable), 32'h0);
    applyStimulus(1'b0, OP_ADDU, CAT_ARITH, 32'h1, 32'h1, 5'd11, 1'b1, 1'b1);
    checkOutput("annul_enable", 32'(mem_write_enable), 32'h0);

    // HI/LO moves
    applyStimulus(1'b0, OP_MTLO, CAT_NOP, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_MFLO, CAT_MOVE, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0);
    checkOutput("mflo_literal", mem_write_data, 32'hCAFE_F00D);
    applyStimulus(1'b0, OP_MTHI, CAT_NOP, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_MTLO, CAT_NOP, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_MFHI, CAT_MOVE, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0);
    checkOutput("mfhi_literal", mem_write_data, 32'h1234_5678);
    checkOutput("mtlo_annul_lo", lo_out, 32'hCAFE_F00D);

    // DIV -7 / 2, held for the stall plus the DONE cycle
    stall_cycles = 0;
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b0, OP_DIV, CAT_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, 1'b0, 1'b0);
      if (stall_request) stall_cycles++;
    end
    applyStimulus(1'b0, OP_MFLO, CAT_MOVE, 32'h0, 32'h0, 5'd14, 1'b1, 1'b0);
`ifdef DIVIDER_EN
    checkOutput("div_stall_cycles", 32'(stall_cycles), 32'd33);
    checkOutput("div_lo", mem_write_data, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi_out, 32'hFFFF_FFFF);
`else
    checkOutput("div_stall_cycles", 32'(stall_cycles), 32'd0);
    checkOutput("div_lo", mem_write_data, 32'hCAFE_F00D);
    checkOutput("div_hi", hi_out, 32'h1234_5678);
`endif

    // DIVU 100 / 7
    for (int i = 0; i < 34; i++)
      applyStimulus(1'b0, OP_DIVU, CAT_DIV, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_MFHI, CAT_MOVE, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0);
`ifdef DIVIDER_EN
    checkOutput("divu_hi", mem_write_data, 32'd2);
    checkOutput("divu_lo", lo_out, 32'd14);
`else
    checkOutput("divu_hi", mem_write_data, 32'h1234_5678);
    checkOutput("divu_lo", lo_out, 32'hCAFE_F00D);
`endif

    // DIVU 5 / 0: no stall, commit after the DONE cycle
    applyStimulus(1'b0, OP_DIVU, CAT_DIV, 32'd5, 32'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("div0_stall", 32'(stall_request), 32'h0);
    nop();
    nop();
`ifdef DIVIDER_EN
    checkOutput("div0_hi", hi_out, 32'd5);
    checkOutput("div0_lo", lo_out, 32'hFFFF_FFFF);
`else
    checkOutput("div0_hi", hi_out, 32'h1234_5678);
    checkOutput("div0_lo", lo_out, 32'hCAFE_F00D);
`endif

    // Annul at BUSY cycle 10
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, OP_DIVU, CAT_DIV, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_DIVU, CAT_DIV, 32'd100, 32'd7, 5'd0, 1'b0, 1'b1);
    checkOutput("annul_stall", 32'(stall_request), 32'h0);
    for (int i = 0; i < 3; i++) nop();
`ifdef DIVIDER_EN
    checkOutput("annul_hi", hi_out, 32'd5);
    checkOutput("annul_lo", lo_out, 32'hFFFF_FFFF);
`else
    checkOutput("annul_hi", hi_out, 32'h1234_5678);
    checkOutput("annul_lo", lo_out, 32'hCAFE_F00D);
`endif

    // Reset at BUSY cycle 20
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, OP_DIV, CAT_DIV, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_DIV, CAT_DIV, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0);
    nop();
    checkOutput("rst_mid_hi", hi_out, 32'h0);
    checkOutput("rst_mid_lo", lo_out, 32'h0);
    checkOutput("rst_mid_stall", 32'(stall_request), 32'h0);
    for (int i = 0; i < 3; i++) nop();

    // DIV 100 / -7 after the abandoned operation
    for (int i = 0; i < 34; i++)
      applyStimulus(1'b0, OP_DIV, CAT_DIV, 32'd100, 32'hFFFF_FFF9, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_MFLO, CAT_MOVE, 32'h0, 32'h0, 5'd16, 1'b1, 1'b0);
`ifdef DIVIDER_EN
    checkOutput("div_neg_lo", mem_write_data, 32'hFFFF_FFF2);
    checkOutput("div_neg_hi", hi_out, 32'd2);
`else
    checkOutput("div_neg_lo", mem_write_data, 32'h0);
    checkOutput("div_neg_hi", hi_out, 32'h0);
`endif
    nop();
    nop();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", compare_count, miss_count);
    $finish;
  end

endmodule
